// File: rtl/i2c_seq_pkg.sv
// Shared encodings for the I2C register-transaction sequencer: FSM states,
// error-bit positions and the R/W bit appended to the 7-bit device address.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_RDY,
    S_TX_ADRW,
    S_TX_REG,
    S_TX_WDATA,
    S_TX_ADRR,
    S_RX,
    S_DONE,
    S_ERR
  } state_e;

  localparam int ERR_LEN = 0;
  localparam int ERR_TMO = 1;

  localparam logic BIT_WRITE = 1'b0;
  localparam logic BIT_READ  = 1'b1;

endpackage

// File: rtl/i2c_seq_rxbuf.sv
// Receive buffer: DEPTH x 8 entries, asynchronous clear, one write port and a
// combinational read port returning 0 for indices beyond the buffer.
module i2c_seq_rxbuf #(
  parameter int DEPTH = 22,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (int'(wr_idx) < DEPTH)) mem_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the registered contents, so a same-cycle write returns old data.
  assign rd_data = (int'(rd_idx) < DEPTH) ? mem_q[rd_idx] : 8'h00;

endmodule

// File: rtl/i2c_reg_seq.sv
// I2C register-transaction sequencer driving a byte-level master handshake.
// Optional watchdog enabled by defining I2C_REG_SEQ_TIMEOUT_EN.
module i2c_reg_seq
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0] DEV_ADR    = 7'h77,
  parameter int         DEPTH      = 22,
  parameter int         START_HOLD = 15,
  parameter int         TIMEOUT    = 65535,
  localparam int        LEN_W      = $clog2(DEPTH + 1),
  localparam int        IDX_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [7:0]       cmd_reg,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       cmd_wdata,
  input  logic             isReady,
  output logic             start,
  output logic             send,
  output logic [7:0]       datasend,
  input  logic             sended,
  output logic             receive,
  input  logic [7:0]       datareceive,
  input  logic             received,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err
);

  localparam int HOLD_W = $clog2(START_HOLD + 1);

  state_e             state_q, state_d;
  logic               write_q, write_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         reg_q, reg_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [1:0]         err_q, err_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               sended_q, received_q;
  logic               snd_edge, rcv_edge, accept, in_tx, wr_en, tmo_hit;

  assign accept   = cmd_valid && (state_q == S_IDLE);
  assign snd_edge = sended & ~sended_q;
  assign rcv_edge = received & ~received_q;
  assign in_tx    = (state_q == S_TX_ADRW) || (state_q == S_TX_REG) ||
                    (state_q == S_TX_WDATA) || (state_q == S_TX_ADRR);

`ifdef I2C_REG_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             adv;

  // Any edge that moves the FSM forward restarts the watchdog.
  assign adv = (in_tx && snd_edge) || ((state_q == S_RX) && rcv_edge);

  always_comb begin
    tmo_d = tmo_q;
    if (accept || adv) tmo_d = '0;
    else if (tmo_q != TMO_W'(TIMEOUT)) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    len_d   = len_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    k_d     = k_q;
    err_d   = err_q;
    hold_d  = (hold_q != '0) ? hold_q - 1'b1 : '0;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        write_d = cmd_write;
        len_d   = cmd_len;
        reg_d   = cmd_reg;
        wdata_d = cmd_wdata;
        k_d     = '0;
        err_d   = 2'b00;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!write_q && ((len_q == '0) || (int'(len_q) > DEPTH))) begin
          err_d[ERR_LEN] = 1'b1;
          state_d        = S_DONE;
        end else begin
          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (tmo_hit) state_d = S_ERR;
        else if (isReady) begin
          state_d = S_TX_ADRW;
          hold_d  = HOLD_W'(START_HOLD);
        end
      end
      S_TX_ADRW: begin
        if (tmo_hit) state_d = S_ERR;
        else if (snd_edge) state_d = S_TX_REG;
      end
      S_TX_REG: begin
        if (tmo_hit) state_d = S_ERR;
        else if (snd_edge) begin
          if (write_q) state_d = S_TX_WDATA;
          else begin
            state_d = S_TX_ADRR;
            hold_d  = HOLD_W'(START_HOLD);
          end
        end
      end
      S_TX_WDATA: begin
        if (tmo_hit) state_d = S_ERR;
        else if (snd_edge) state_d = S_DONE;
      end
      S_TX_ADRR: begin
        if (tmo_hit) state_d = S_ERR;
        else if (snd_edge) state_d = S_RX;
      end
      S_RX: begin
        if (tmo_hit) state_d = S_ERR;
        else if (rcv_edge) begin
          wr_en = 1'b1;
          k_d   = k_q + 1'b1;
          if ((LEN_W'(k_q) + 1'b1) == len_q) state_d = S_DONE;
        end
      end
      S_ERR: begin
        err_d[ERR_TMO] = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifndef I2C_REG_SEQ_TIMEOUT_EN
    err_d[ERR_TMO] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      len_q      <= '0;
      k_q        <= '0;
      err_q      <= 2'b00;
      hold_q     <= '0;
      sended_q   <= 1'b0;
      received_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      len_q      <= len_d;
      k_q        <= k_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
      sended_q   <= sended;
      received_q <= received;
    end
  end

  always_ff @(posedge clk) begin
    reg_q   <= reg_d;
    wdata_q <= wdata_d;
  end

  // Strobes decode from the state register so an async reset drops them at once.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    send      = in_tx;
    receive   = (state_q == S_RX);
    start     = ((state_q == S_TX_ADRW) || (state_q == S_TX_ADRR)) && (hold_q != '0);
    err       = err_q;
    case (state_q)
      S_TX_ADRW:  datasend = {DEV_ADR, BIT_WRITE};
      S_TX_REG:   datasend = reg_q;
      S_TX_WDATA: datasend = wdata_q;
      S_TX_ADRR:  datasend = {DEV_ADR, BIT_READ};
      default:    datasend = 8'h00;
    endcase
  end

  i2c_seq_rxbuf #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_rxbuf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (k_q),
    .wr_data (datareceive),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq with a behavioural byte-level master model.
module tb_i2c_reg_seq;

  localparam int LEN_W = 5;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0]       cmd_reg = 8'h00, cmd_wdata = 8'h00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             isReady = 1'b1, sended = 1'b0, received = 1'b0;
  logic [7:0]       datareceive = 8'h00;
  logic [IDX_W-1:0] rd_idx = '0;
  logic             cmd_ready, start, send, receive, busy, done;
  logic [7:0]       datasend, rd_data;
  logic [1:0]       err;

  int n_chk = 0, n_err = 0;
  int sended_hold = 1;
  logic [7:0] rx_seed = 8'h00;
  int rx_n = 0, rx_stop = 0;
  logic [7:0] tx_log[$];
  int start_cyc = 0, start_pul = 0, send_cyc = 0;
  logic start_prev = 1'b0;

  always #5 clk = ~clk;

  i2c_reg_seq #(
    .DEV_ADR(7'h77), .DEPTH(22), .START_HOLD(15), .TIMEOUT(100)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .isReady(isReady), .start(start), .send(send), .datasend(datasend), .sended(sended),
    .receive(receive), .datareceive(datareceive), .received(received),
    .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .done(done), .err(err)
  );

  // Master model: logs each byte offered, acknowledges after 20 cycles,
  // returns rx_seed + 7*n for read byte n until rx_stop bytes are given.
  initial begin
    forever begin
      @(negedge clk);
      if (send) begin
        tx_log.push_back(datasend);
        repeat (20) @(negedge clk);
        sended = 1'b1;
        repeat (sended_hold) @(negedge clk);
        sended = 1'b0;
      end else if (receive && (rx_n < rx_stop)) begin
        repeat (4) @(negedge clk);
        datareceive = rx_seed + 8'(7 * rx_n);
        received = 1'b1;
        @(negedge clk);
        received = 1'b0;
        rx_n++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (start) start_cyc++;
      if (start && !start_prev) start_pul++;
      if (send) send_cyc++;
      start_prev = start;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue_cmd(input logic wr, input logic [7:0] rg, input logic [LEN_W-1:0] len,
                           input logic [7:0] wd, input logic [7:0] seed, input int stop);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_reg = rg; cmd_len = len; cmd_wdata = wd;
    rx_seed = seed; rx_stop = stop;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    tx_log.delete();
    rx_n = 0; start_cyc = 0; start_pul = 0; send_cyc = 0;
  endtask

  task automatic wait_done(input string name, output logic [1:0] e);
    bit got;
    got = 1'b0;
    e = 2'bxx;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; e = err; end
    end
    chk({name, "_done"}, 32'(got), 32'd1);
    @(negedge clk);
    chk({name, "_idle"}, {done, busy, cmd_ready}, 3'b001);
  endtask

  task automatic chk_buf(input string name, input int idx, input logic [7:0] exp);
    rd_idx = IDX_W'(idx);
    #1;
    chk(name, rd_data, exp);
  endtask

  typedef struct {
    logic             wr;
    logic [7:0]       rg;
    logic [LEN_W-1:0] len;
    logic [7:0]       wd;
    logic [7:0]       seed;
    int               nbytes;
    logic [7:0]       b0, b1, b2;
    int               spul;
    int               scyc;
    logic [1:0]       err;
    int               nrx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [1:0] e;
    logic [7:0] eb;
    logic [7:0] wexp[3];
    bit got;

    vecs[0] = '{1'b0, 8'hD0, 5'd1,  8'h00, 8'h55, 3, 8'hEE, 8'hD0, 8'hEF, 2, 30, 2'b00, 1};
    vecs[1] = '{1'b0, 8'hAA, 5'd22, 8'h00, 8'h10, 3, 8'hEE, 8'hAA, 8'hEF, 2, 30, 2'b00, 22};
    vecs[2] = '{1'b1, 8'hF4, 5'd0,  8'h2E, 8'h00, 3, 8'hEE, 8'hF4, 8'h2E, 1, 15, 2'b00, 0};
    vecs[3] = '{1'b0, 8'h11, 5'd0,  8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0,  2'b01, 0};
    vecs[4] = '{1'b0, 8'h11, 5'd23, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0,  2'b01, 0};
    vecs[5] = '{1'b0, 8'h12, 5'd2,  8'h00, 8'hA0, 3, 8'hEE, 8'h12, 8'hEF, 2, 30, 2'b00, 2};

    repeat (3) @(negedge clk);
    chk("rst_ctl", {cmd_ready, start, send, receive, busy, done}, 6'b100000);
    chk("rst_dsend_err", {datasend, err}, 10'h000);
    chk_buf("rst_buf0", 0, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 6; v++) begin
      issue_cmd(vecs[v].wr, vecs[v].rg, vecs[v].len, vecs[v].wd, vecs[v].seed, 32);
      wait_done($sformatf("v%0d", v), e);
      chk($sformatf("v%0d_err", v), e, vecs[v].err);
      chk($sformatf("v%0d_nbytes", v), tx_log.size(), vecs[v].nbytes);
      for (int b = 0; b < tx_log.size() && b < 3; b++) begin
        eb = (b == 0) ? vecs[v].b0 : (b == 1) ? vecs[v].b1 : vecs[v].b2;
        chk($sformatf("v%0d_byte%0d", v, b), tx_log[b], eb);
      end
      chk($sformatf("v%0d_start_pulses", v), start_pul, vecs[v].spul);
      chk($sformatf("v%0d_start_cycles", v), start_cyc, vecs[v].scyc);
      chk($sformatf("v%0d_rx_bytes", v), rx_n, vecs[v].nrx);
      for (int k = 0; k < vecs[v].nrx; k++)
        chk_buf($sformatf("v%0d_buf%0d", v, k), k, vecs[v].seed + 8'(7 * k));
    end

    chk_buf("buf2_untouched", 2, 8'h1E);
    chk_buf("buf21_kept", 21, 8'hA3);
    chk_buf("rd_idx22_zero", 22, 8'h00);
    chk_buf("rd_idx31_zero", 31, 8'h00);

    // Bad length: LOAD then DONE, no bus activity.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_len = 5'd23;
    @(posedge clk); #1;
    cmd_valid = 1'b0; send_cyc = 0; start_cyc = 0;
    @(negedge clk);
    chk("len23_load", {done, busy}, 2'b01);
    @(negedge clk);
    chk("len23_done", {done, err}, 3'b101);
    @(negedge clk);
    chk("len23_idle", {done, busy}, 2'b00);
    chk("len23_nobus", send_cyc + start_cyc, 0);

    // Held isReady low, then a long sended level on every byte.
    isReady = 1'b0;
    sended_hold = 10;
    issue_cmd(1'b1, 8'h01, 5'd0, 8'h02, 8'h00, 0);
    repeat (5) @(negedge clk);
    chk("rdy_wait", {busy, send, start}, 3'b100);
    chk("rdy_nosend", send_cyc, 0);
    isReady = 1'b1;
    @(negedge clk);
    chk("rdy_go", {send, start, datasend}, {2'b11, 8'hEE});
    wait_done("hold", e);
    chk("hold_err", e, 2'b00);
    chk("hold_nbytes", tx_log.size(), 3);
    wexp = '{8'hEE, 8'h01, 8'h02};
    for (int b = 0; b < tx_log.size() && b < 3; b++)
      chk($sformatf("hold_byte%0d", b), tx_log[b], wexp[b]);
    repeat (15) @(negedge clk);
    sended_hold = 1;

`ifdef I2C_REG_SEQ_TIMEOUT_EN
    issue_cmd(1'b0, 8'h33, 5'd4, 8'h00, 8'h60, 2);
    wait_done("tmo", e);
    chk("tmo_err", e, 2'b10);
    chk("tmo_rx", rx_n, 2);
    chk_buf("tmo_buf0", 0, 8'h60);
    chk_buf("tmo_buf1", 1, 8'h67);
    chk_buf("tmo_buf2", 2, 8'h1E);
`endif

    // Reset while stalled mid-receive.
    issue_cmd(1'b0, 8'h44, 5'd5, 8'h00, 8'h30, 2);
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (rx_n == 2) got = 1'b1;
    end
    chk("rst_rx_partial", 32'(got), 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_rx_stall", {receive, busy}, 2'b11);
    rd_idx = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_async_out", {start, send, receive, busy, done, cmd_ready, err, datasend},
        {5'b00000, 1'b1, 2'b00, 8'h00});
    chk("rst_async_buf", rd_data, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
